// File: rtl/demux_1_4_buf_pkg.sv
// Shared constants for the 1-to-4 buffered demux: channel count, selector
// width and the legal queue depths.
package demux_1_4_buf_pkg;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int DEPTH_LEGAL_A = 2;
  localparam int DEPTH_LEGAL_B = 4;

  function automatic bit depth_legal(input int d);
    return (d == DEPTH_LEGAL_A) || (d == DEPTH_LEGAL_B);
  endfunction
endpackage

// File: rtl/demux_1_4_buf_q.sv
// Single output-channel queue: circular buffer with occupancy counter.
// Storage is not reset; head reads as zero while empty.
module demux_q
  import demux_1_4_buf_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     occ,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   occ_q, occ_d;
  logic          do_push, do_pop;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == FULL_OCC);
  assign occ     = occ_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + (PW+1)'(1);
      2'b01:   occ_d = occ_q - (PW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // rstn gates the write so nothing lands in storage while held in reset
  always_ff @(posedge clk) begin
    if (do_push && rstn) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/demux_1_4_buf.sv
// 1-to-4 demux with a small FIFO per output channel and sticky per-channel
// overflow (producer stalled on a full queue) flags.
module demux_1_4_buf
  import demux_1_4_buf_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [W-1:0]     in_data,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [W-1:0]     out_data0,
  output logic [W-1:0]     out_data1,
  output logic [W-1:0]     out_data2,
  output logic [W-1:0]     out_data3,
  output logic [NCH-1:0]   cnt_ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_depth_err
    $error("demux_1_4_buf: DEPTH must be 2 or 4");
  end

  logic [NCH-1:0]         sel_oh, q_push, q_pop, q_full, q_empty;
  logic [NCH-1:0][W-1:0]  q_dout;
  logic [NCH-1:0][PW:0]   q_occ;
  logic [NCH-1:0]         cnt_ovf_q, cnt_ovf_d;

  always_comb begin
    sel_oh         = '0;
    sel_oh[in_sel] = 1'b1;
  end

  // Depends only on the selector and registered occupancy, never on out_ready
  assign in_ready = (q_occ[in_sel] < FULL_OCC);

  assign q_push    = sel_oh & {NCH{in_valid & in_ready}};
  assign q_pop     = out_ready & ~q_empty;
  assign out_valid = ~q_empty;
  assign cnt_ovf_d = cnt_ovf_q | (sel_oh & q_full & {NCH{in_valid}});
  assign cnt_ovf   = cnt_ovf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_ovf_q <= '0;
    else       cnt_ovf_q <= cnt_ovf_d;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_q
    demux_q #(.W(W), .DEPTH(DEPTH)) u_q (
      .clk   (clk),
      .rstn  (rstn),
      .push  (q_push[k]),
      .pop   (q_pop[k]),
      .din   (in_data),
      .dout  (q_dout[k]),
      .occ   (q_occ[k]),
      .full  (q_full[k]),
      .empty (q_empty[k])
    );
  end

  assign out_data0 = q_dout[0];
  assign out_data1 = q_dout[1];
  assign out_data2 = q_dout[2];
  assign out_data3 = q_dout[3];
endmodule

// File: tb/tb_demux_1_4_buf.sv
// Directed bench for demux_1_4_buf: DEPTH=2 instance for most cases, a
// DEPTH=4 instance sharing the stimulus for the deeper-queue checks.
module tb_demux_1_4_buf;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic [1:0]    in_sel;
  logic [W-1:0]  in_data;
  logic [3:0]    out_ready;

  logic          in_ready, in_ready4;
  logic [3:0]    out_valid, out_valid4, cnt_ovf, cnt_ovf4;
  logic [W-1:0]  od0, od1, od2, od3, e0, e1, e2, e3;
  logic [3:0][W-1:0] od, e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_1_4_buf #(.W(W), .DEPTH(2)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data0(od0), .out_data1(od1),
    .out_data2(od2), .out_data3(od3), .cnt_ovf(cnt_ovf)
  );

  demux_1_4_buf #(.W(W), .DEPTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready4),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data0(e0), .out_data1(e1),
    .out_data2(e2), .out_data3(e3), .cnt_ovf(cnt_ovf4)
  );

  assign od = {od3, od2, od1, od0};
  assign e  = {e3, e2, e1, e0};

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'h0;
    step();
    rstn = 1'b1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [W-1:0] d);
    in_valid = 1'b1; in_sel = sel; in_data = d;
    #1;
  endtask

  initial begin
    // reset state
    rstn = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'h0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ovf",   32'(cnt_ovf),   32'h0);
    chk("rst_ready", 32'(in_ready),  32'h1);
    chk("rst_data0", od0, 32'h0);
    chk("rst_data3", od3, 32'h0);
    step();
    rstn = 1'b1;

    // single word, one-cycle latency
    drive(2'd2, 32'h1111_1111);
    step();
    in_valid = 1'b0;
    chk("lat_valid", 32'(out_valid), 32'h4);
    chk("lat_data2", od2, 32'h1111_1111);
    chk("lat_data0", od0, 32'h0);

    // overflow on channel 1, then in-order drain
    do_reset();
    drive(2'd1, 32'hA1); chk("ovf_rdy0", 32'(in_ready), 32'h1); step();
    drive(2'd1, 32'hA2); chk("ovf_rdy1", 32'(in_ready), 32'h1); step();
    drive(2'd1, 32'hA3); chk("ovf_rdy2", 32'(in_ready), 32'h0); step();
    in_valid = 1'b0;
    chk("ovf_flag",  32'(cnt_ovf),   32'h2);
    chk("ovf_valid", 32'(out_valid), 32'h2);
    chk("ovf_head",  od1, 32'hA1);
    step();
    chk("ovf_hold",  od1, 32'hA1);
    out_ready = 4'b0010;
    step();
    chk("ovf_2nd",   od1, 32'hA2);
    step();
    chk("ovf_empty", 32'(out_valid), 32'h0);
    chk("ovf_zero",  od1, 32'h0);
    chk("ovf_stick", 32'(cnt_ovf),   32'h2);

    // full channel 3 with same-cycle pop: push refused, accepted next cycle
    do_reset();
    drive(2'd3, 32'hB0); step();
    drive(2'd3, 32'hB1); step();
    drive(2'd3, 32'hB2); out_ready = 4'b1000;
    chk("pp_rdy_full", 32'(in_ready), 32'h0);
    step();
    out_ready = 4'h0; #1;
    chk("pp_head",   od3, 32'hB1);
    chk("pp_rdy_nx", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("pp_hold",   od3, 32'hB1);
    chk("pp_ovf",    32'(cnt_ovf), 32'h8);
    out_ready = 4'b1000;
    step();
    chk("pp_b2",     od3, 32'hB2);
    step();
    chk("pp_empty",  32'(out_valid), 32'h0);

    // round-robin, 1 word/cycle, each visible exactly one cycle
    do_reset();
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 32'hA0 + 32'(i));
      chk($sformatf("rr_rdy%0d", i), 32'(in_ready), 32'h1);
      step();
      chk($sformatf("rr_vld%0d", i), 32'(out_valid), 32'(4'b0001 << i));
      chk($sformatf("rr_dat%0d", i), od[i], 32'hA0 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("rr_done", 32'(out_valid), 32'h0);

    // asynchronous reset mid-stream
    do_reset();
    drive(2'd0, 32'hC0); step();
    drive(2'd0, 32'hC1); step();
    drive(2'd0, 32'hC2); step();
    in_valid = 1'b0;
    chk("ar_pre_ovf", 32'(cnt_ovf), 32'h1);
    #3;
    rstn = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_ovf",   32'(cnt_ovf),   32'h0);
    chk("ar_data0", od0, 32'h0);
    drive(2'd0, 32'hEE);
    chk("ar_rdy", 32'(in_ready), 32'h1);
    step();
    rstn = 1'b1; in_valid = 1'b0;
    step();
    chk("ar_nostale", 32'(out_valid), 32'h0);
    chk("ar_zero",    od0, 32'h0);
    drive(2'd0, 32'hD0); step();
    in_valid = 1'b0;
    chk("ar_fresh", od0, 32'hD0);

    // DEPTH=4 instance: four accepted, fifth stalls, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'd2, 32'hF0 + 32'(i));
      chk($sformatf("d4_rdy%0d", i), 32'(in_ready4), 32'h1);
      step();
    end
    drive(2'd2, 32'hF4);
    chk("d4_rdy_full", 32'(in_ready4), 32'h0);
    step();
    in_valid = 1'b0;
    chk("d4_ovf", 32'(cnt_ovf4), 32'h4);
    out_ready = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d4_dat%0d", i), e[2], 32'hF0 + 32'(i));
      step();
    end
    chk("d4_empty", 32'(out_valid4), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
